// File: rtl/async_fifo.sv
// ---------------------------------------------------------------------------
// async_fifo
// Single-clock FIFO of 2^ASIZE words of DSIZE bits with registered read data,
// a read-valid strobe and full / almost-full / empty / almost-empty flags.
//
// Optional feature macro: ASYNC_FIFO_ERR_EN
//   When defined, adds sticky outputs ovf (a write was dropped because the
//   FIFO was full) and udf (a read was ignored because the FIFO was empty).
//   Both clear only on rst.
//
// Pointers are ASIZE+1 bits wide. The low ASIZE bits address the array and
// the extra bit tells a full FIFO apart from an empty one, so the occupancy
// is simply wptr - rptr in modulo arithmetic.
//
// Status flags are registered. They are computed from the next-state
// pointers, so after every edge they match the newly registered pointers.
// A write that arrives while wfull is set is dropped, and a read that
// arrives while repty is set is ignored. This holds even when the opposite
// port is accepted in the same cycle.
//
// ALMST is expected to lie between 0 and 2^ASIZE.
// ---------------------------------------------------------------------------
module async_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 6,
    parameter int ALMST = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wreq,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             wfull_almst,
    input  logic             rreq,
    output logic [DSIZE-1:0] rdata,
    output logic             rdvld,
    output logic             repty,
    output logic             repty_almst
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam int DEPTH = 1 << ASIZE;

    // Occupancy thresholds, expressed at pointer width.
    localparam logic [ASIZE:0] FULL_LVL   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(DEPTH - ALMST);
    localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(ALMST);
    localparam logic [ASIZE:0] PTR_ONE    = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] PTR_ZERO   = (ASIZE+1)'(0);

    // Storage. Contents are deliberately not reset; the pointers alone
    // define which words are valid.
    logic [DSIZE-1:0] mem_q [DEPTH];

    // Pointer and output state.
    logic [ASIZE:0]   wptr_q,        wptr_d;
    logic [ASIZE:0]   rptr_q,        rptr_d;
    logic [DSIZE-1:0] rdata_q,       rdata_d;
    logic             rdvld_q,       rdvld_d;
    logic             wfull_q,       wfull_d;
    logic             wfull_almst_q, wfull_almst_d;
    logic             repty_q,       repty_d;
    logic             repty_almst_q, repty_almst_d;
`ifdef ASYNC_FIFO_ERR_EN
    logic             ovf_q,         ovf_d;
    logic             udf_q,         udf_d;
`endif

    // Per-cycle decode.
    logic             wr_en_s;
    logic             rd_en_s;
    logic [ASIZE:0]   count_d_s;
    logic [ASIZE-1:0] waddr_s;
    logic [ASIZE-1:0] raddr_s;

    // Accept decisions, which depend only on the registered flags.
    always_comb begin
        wr_en_s = wreq & ~wfull_q;
        rd_en_s = rreq & ~repty_q;
        waddr_s = wptr_q[ASIZE-1:0];
        raddr_s = rptr_q[ASIZE-1:0];
    end

    // Next-state pointers, read data and status flags.
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        rdata_d       = rdata_q;
        rdvld_d       = 1'b0;
        count_d_s     = PTR_ZERO;
        wfull_d       = 1'b0;
        wfull_almst_d = 1'b0;
        repty_d       = 1'b1;
        repty_almst_d = 1'b1;

        if (wr_en_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_en_s) begin
            rptr_d  = rptr_q + PTR_ONE;
            rdata_d = mem_q[raddr_s];
            rdvld_d = 1'b1;
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
            rdvld_d = 1'b0;
        end

        count_d_s     = wptr_d - rptr_d;
        wfull_d       = (count_d_s == FULL_LVL);
        wfull_almst_d = (count_d_s >= AFULL_LVL);
        repty_d       = (count_d_s == PTR_ZERO);
        repty_almst_d = (count_d_s <= AEMPTY_LVL);
    end

`ifdef ASYNC_FIFO_ERR_EN
    // Sticky error flags, set by a rejected request and held until reset.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wreq && wfull_q) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (rreq && repty_q) begin
            udf_d = 1'b1;
        end else begin
            udf_d = udf_q;
        end
    end
`endif

    // State registers with synchronous reset to the empty condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= PTR_ZERO;
            rptr_q        <= PTR_ZERO;
            rdata_q       <= '0;
            rdvld_q       <= 1'b0;
            wfull_q       <= 1'b0;
            wfull_almst_q <= 1'b0;
            repty_q       <= 1'b1;
            repty_almst_q <= 1'b1;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            rdata_q       <= rdata_d;
            rdvld_q       <= rdvld_d;
            wfull_q       <= wfull_d;
            wfull_almst_q <= wfull_almst_d;
            repty_q       <= repty_d;
            repty_almst_q <= repty_almst_d;
        end
    end

`ifdef ASYNC_FIFO_ERR_EN
    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
`endif

    // Array write port. Writes are gated off while reset is applied.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[waddr_s] <= wdata;
        end
    end

    // Output drive from registered state.
    always_comb begin
        wfull       = wfull_q;
        wfull_almst = wfull_almst_q;
        rdata       = rdata_q;
        rdvld       = rdvld_q;
        repty       = repty_q;
        repty_almst = repty_almst_q;
    end

`ifdef ASYNC_FIFO_ERR_EN
    // Error flag outputs.
    always_comb begin
        ovf = ovf_q;
        udf = udf_q;
    end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// ---------------------------------------------------------------------------
// tb_async_fifo
// Directed, self-checking bench for async_fifo with default parameters
// (8-bit data, depth 64, margin 12). Expected values come from simple
// occupancy and sequence arithmetic kept in the bench.
// The ovf/udf checks are compiled in when ASYNC_FIFO_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_async_fifo;

    logic       clk;
    logic       rst;
    logic       wreq;
    logic [7:0] wdata;
    logic       wfull;
    logic       wfull_almst;
    logic       rreq;
    logic [7:0] rdata;
    logic       rdvld;
    logic       repty;
    logic       repty_almst;
`ifdef ASYNC_FIFO_ERR_EN
    logic       ovf;
    logic       udf;
`endif

    int n_assert;
    int n_fail;

    async_fifo #(.DSIZE(8), .ASIZE(6), .ALMST(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .wreq        (wreq),
        .wdata       (wdata),
        .wfull       (wfull),
        .wfull_almst (wfull_almst),
        .rreq        (rreq),
        .rdata       (rdata),
        .rdvld       (rdvld),
        .repty       (repty),
        .repty_almst (repty_almst)
`ifdef ASYNC_FIFO_ERR_EN
        ,
        .ovf         (ovf),
        .udf         (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report and count a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mc;
        int nw;
        int nr;
        bit exp_wr;
        bit exp_rd;

        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wreq     = 1'b1;
        wdata    = 8'h77;
        rreq     = 1'b1;

        // Reset; requests raised during reset must be ignored.
        step();
        step();
        rst  = 1'b0;
        wreq = 1'b0;
        rreq = 1'b0;
        chk("rst_repty",       32'(repty),       32'd1);
        chk("rst_repty_almst", 32'(repty_almst), 32'd1);
        chk("rst_wfull",       32'(wfull),       32'd0);
        chk("rst_wfull_almst", 32'(wfull_almst), 32'd0);
        chk("rst_rdvld",       32'(rdvld),       32'd0);
        chk("rst_rdata",       32'(rdata),       32'd0);
`ifdef ASYNC_FIFO_ERR_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_udf", 32'(udf), 32'd0);
`endif

        // Write 33 words, then drain them with rreq held.
        for (int i = 1; i <= 33; i++) begin
            wreq  = 1'b1;
            wdata = 8'(i);
            step();
            chk("w33_repty",       32'(repty),       32'd0);
            chk("w33_repty_almst", 32'(repty_almst), 32'(i <= 12));
            chk("w33_rdvld",       32'(rdvld),       32'd0);
        end
        wreq = 1'b0;
        rreq = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            chk("r33_rdvld",       32'(rdvld),       32'd1);
            chk("r33_rdata",       32'(rdata),       32'(k));
            chk("r33_repty",       32'(repty),       32'(k == 33));
            chk("r33_repty_almst", 32'(repty_almst), 32'((33 - k) <= 12));
        end
        rreq = 1'b0;
        step();
        chk("r33_idle_rdvld", 32'(rdvld), 32'd0);
        chk("r33_hold_rdata", 32'(rdata), 32'd33);
`ifdef ASYNC_FIFO_ERR_EN
        chk("r33_udf", 32'(udf), 32'd0);
`endif

        // Write 70 words with no reads; words 65..70 are dropped.
        for (int i = 1; i <= 70; i++) begin
            wreq  = 1'b1;
            wdata = 8'(i);
            step();
            mc = (i < 64) ? i : 64;
            chk("w70_wfull",       32'(wfull),       32'(mc == 64));
            chk("w70_wfull_almst", 32'(wfull_almst), 32'(mc >= 52));
        end
        wreq = 1'b0;
`ifdef ASYNC_FIFO_ERR_EN
        chk("w70_ovf", 32'(ovf), 32'd1);
`endif
        rreq = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            chk("r64_rdvld", 32'(rdvld), 32'd1);
            chk("r64_rdata", 32'(rdata), 32'(k));
            chk("r64_wfull", 32'(wfull), 32'd0);
        end
        rreq = 1'b0;
        step();
        chk("r64_repty", 32'(repty), 32'd1);
        chk("r64_rdvld_end", 32'(rdvld), 32'd0);
`ifdef ASYNC_FIFO_ERR_EN
        chk("r64_udf_clear", 32'(udf), 32'd0);
`endif

        // Write 1..70 while reading every cycle; the first read is ignored.
        rreq = 1'b1;
        for (int i = 1; i <= 71; i++) begin
            wreq  = (i <= 70);
            wdata = 8'(i);
            step();
            chk("wr_wfull", 32'(wfull), 32'd0);
            chk("wr_rdvld", 32'(rdvld), 32'(i != 1));
            if (i != 1) begin
                chk("wr_rdata", 32'(rdata), 32'(i - 1));
            end
        end
        wreq = 1'b0;
        rreq = 1'b0;
        step();
        chk("wr_repty", 32'(repty), 32'd1);
`ifdef ASYNC_FIFO_ERR_EN
        chk("wr_udf", 32'(udf), 32'd1);
`endif

        // 100 words with bursty concurrent reads against an occupancy model.
        mc = 0;
        nw = 0;
        nr = 0;
        for (int cyc = 0; cyc < 600 && (nw < 100 || mc > 0); cyc++) begin
            wreq   = (nw < 100);
            wdata  = 8'(nw + 1);
            rreq   = ((cyc % 16) < 6) || (nw >= 100);
            exp_wr = wreq && (mc != 64);
            exp_rd = rreq && (mc != 0);
            step();
            if (exp_wr) begin
                nw++;
                mc++;
            end
            if (exp_rd) begin
                mc--;
            end
            chk("b_rdvld", 32'(rdvld), 32'(exp_rd));
            if (exp_rd) begin
                nr++;
                chk("b_rdata", 32'(rdata), 32'(8'(nr)));
            end
            chk("b_wfull", 32'(wfull), 32'(mc == 64));
            chk("b_repty", 32'(repty), 32'(mc == 0));
        end
        wreq = 1'b0;
        rreq = 1'b0;
        chk("b_reads_done", 32'(nr), 32'd100);

        // Reset with 20 words stored, then a single write/read of 0xA5.
        for (int i = 1; i <= 20; i++) begin
            wreq  = 1'b1;
            wdata = 8'(i + 200);
            step();
        end
        chk("r20_repty_pre", 32'(repty), 32'd0);
        rst  = 1'b1;
        rreq = 1'b1;
        step();
        rst  = 1'b0;
        wreq = 1'b0;
        rreq = 1'b0;
        chk("r20_repty",       32'(repty),       32'd1);
        chk("r20_rdvld",       32'(rdvld),       32'd0);
        chk("r20_rdata",       32'(rdata),       32'd0);
        chk("r20_repty_almst", 32'(repty_almst), 32'd1);
        chk("r20_wfull_almst", 32'(wfull_almst), 32'd0);
`ifdef ASYNC_FIFO_ERR_EN
        chk("r20_ovf", 32'(ovf), 32'd0);
        chk("r20_udf", 32'(udf), 32'd0);
`endif
        wreq  = 1'b1;
        wdata = 8'hA5;
        step();
        wreq = 1'b0;
        chk("a5_repty_w", 32'(repty), 32'd0);
        rreq = 1'b1;
        step();
        rreq = 1'b0;
        chk("a5_rdvld", 32'(rdvld), 32'd1);
        chk("a5_rdata", 32'(rdata), 32'hA5);
        chk("a5_repty", 32'(repty), 32'd1);
        step();
        chk("a5_rdvld_end", 32'(rdvld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
